// File: rtl/ioctl_upload_server.sv
// HPS upload server: pauses the core and answers ioctl_rd byte reads from a variable-latency memory port.
// Latency: 2+ cycles from rd strobe to data, ioctl_wait stalls the HPS meanwhile; out-of-range reads answer FILL in 1 cycle.
module ioctl_upload_server #(
  parameter int         AW      = 12,
  parameter int         SIZE    = 4096,
  parameter logic [7:0] INDEX   = 8'd4,
  parameter logic [7:0] FILL    = 8'hFF,
  parameter int         TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_data,
  input  logic          mem_valid,
  output logic          active,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, PAUSING, READY, WAIT_MEM} state_t;

  localparam logic [24:0] SIZE_W  = 25'(SIZE);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          sel;
  logic          sel_q, sel_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          pause_req_q, pause_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          active_q, active_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;

  assign sel = ioctl_upload && (ioctl_index == INDEX);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    din_d       = din_q;
    wait_d      = wait_q;
    pause_req_d = pause_req_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    active_d    = active_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    // Losing the session abandons everything except the sticky error.
    if (state_q != IDLE && !sel) begin
      state_d     = IDLE;
      pause_req_d = 1'b0;
      active_d    = 1'b0;
      wait_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel && !sel_q) begin
            state_d     = PAUSING;
            pause_req_d = 1'b1;
            active_d    = 1'b1;
            wait_d      = 1'b1;
            err_d       = 1'b0;
          end
        end
        PAUSING: begin
          if (ioctl_rd) err_d = 1'b1;
          if (paused) begin
            state_d = READY;
            wait_d  = 1'b0;
          end
        end
        READY: begin
          if (!paused) err_d = 1'b1;
          if (ioctl_rd) begin
            if (ioctl_addr < SIZE_W) begin
              mem_addr_d = ioctl_addr[AW-1:0];
              mem_rd_d   = 1'b1;
              wait_d     = 1'b1;
              cnt_d      = 8'd0;
              state_d    = WAIT_MEM;
            end else begin
              din_d = FILL;
            end
          end
        end
        WAIT_MEM: begin
          if (!paused || ioctl_rd) err_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
          // Data arriving on the timeout cycle still counts as a good read.
          if (mem_valid) begin
            din_d   = mem_data;
            wait_d  = 1'b0;
            state_d = READY;
          end else if (cnt_q == TO_LAST) begin
            din_d   = FILL;
            wait_d  = 1'b0;
            err_d   = 1'b1;
            state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      din_q       <= 8'd0;
      wait_q      <= 1'b0;
      pause_req_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      pause_req_q <= pause_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      active_q    <= active_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign active     = active_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Bench for ioctl_upload_server: directed uploads, a simple latency-programmable memory, and a read-completion scoreboard.
module tb_ioctl_upload_server;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        pause_req;
  logic        paused;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        active;
  logic        err;

  ioctl_upload_server dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .pause_req    (pause_req),
    .paused       (paused),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .active       (active),
    .err          (err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] din;
    int         wcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          rds_issued = 0;
  int          rds_seen = 0;
  int          mem_lat = 1;
  int          mem_rd_cnt = 0;
  logic [11:0] last_mem_addr = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory: data = addr[7:0] ^ 8'hB5, mem_valid pulses mem_lat cycles after mem_rd.
  initial begin
    logic [11:0] a;
    mem_valid = 1'b0;
    mem_data  = 8'd0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (mem_rd) begin
        a = mem_addr;
        last_mem_addr = mem_addr;
        if (mem_lat >= 0) begin
          repeat (mem_lat) @(posedge clk_sys);
          #1 mem_valid = 1'b1;
          mem_data  = a[7:0] ^ 8'hB5;
          @(posedge clk_sys);
          #1 mem_valid = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (mem_rd === 1'b1) mem_rd_cnt++;
  end

  // Monitor: each accepted read completes when ioctl_wait is low; check byte and stall length.
  initial forever begin
    exp_t e;
    int   n;
    wait (rds_issued != rds_seen);
    e = exp_q.pop_front();
    n = 0;
    @(negedge clk_sys);
    while (ioctl_wait === 1'b1 && n < 400) begin
      n++;
      @(negedge clk_sys);
    end
    chk("rd_din", {24'd0, ioctl_din}, {24'd0, e.din});
    chk("rd_wait_cycles", n, e.wcyc);
    rds_seen++;
  end

  task automatic do_rd(input logic [24:0] addr, input bit expect_it,
                       input logic [7:0] edin, input int ewcyc);
    exp_t e;
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    @(posedge clk_sys);
    #1 ioctl_rd = 1'b0;
    if (expect_it) begin
      e.din  = edin;
      e.wcyc = ewcyc;
      exp_q.push_back(e);
      rds_issued++;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (rds_seen != rds_issued && k < 600) begin
      @(negedge clk_sys);
      k++;
    end
    if (rds_seen != rds_issued) begin
      tests++;
      fails++;
      $display("FAIL wait_done: read completion not seen within 600 cycles");
      $fatal(1, "bench stalled");
    end
  endtask

  initial begin
    int c0;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    paused       = 1'b0;
    #2;
    chk("rst_din", {24'd0, ioctl_din}, 32'h0);
    chk("rst_wait", {31'd0, ioctl_wait}, 32'h0);
    chk("rst_pause_req", {31'd0, pause_req}, 32'h0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'h0);
    chk("rst_active", {31'd0, active}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;

    // 1: session start and pause handshake
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd4;
    @(negedge clk_sys);
    chk("t1_pause_req", {31'd0, pause_req}, 32'h1);
    chk("t1_active", {31'd0, active}, 32'h1);
    chk("t1_wait_pausing", {31'd0, ioctl_wait}, 32'h1);
    repeat (2) @(negedge clk_sys);
    chk("t1_wait_before_paused", {31'd0, ioctl_wait}, 32'h1);
    paused = 1'b1;
    @(negedge clk_sys);
    chk("t1_wait_after_paused", {31'd0, ioctl_wait}, 32'h0);

    // 2: in-range read, data 4 cycles after mem_rd
    c0 = mem_rd_cnt;
    mem_lat = 4;
    do_rd(25'h010, 1'b1, 8'hA5, 5);
    wait_done();
    chk("t2_mem_rd_pulses", mem_rd_cnt - c0, 1);
    chk("t2_mem_addr", {20'd0, last_mem_addr}, 32'h010);
    chk("t2_err", {31'd0, err}, 32'h0);

    // 3: address == SIZE is out of range
    c0 = mem_rd_cnt;
    do_rd(25'h1000, 1'b1, 8'hFF, 0);
    wait_done();
    chk("t3_no_mem_rd", mem_rd_cnt - c0, 0);
    do_rd(25'h10_0010, 1'b1, 8'hFF, 0);
    wait_done();
    chk("t3_wide_addr_no_mem_rd", mem_rd_cnt - c0, 0);

    // 4: timeout, then a stray late mem_valid
    mem_lat = 265;
    do_rd(25'h030, 1'b1, 8'hFF, 255);
    wait_done();
    chk("t4_err", {31'd0, err}, 32'h1);
    repeat (14) @(negedge clk_sys);
    chk("t4_din_after_stray", {24'd0, ioctl_din}, 32'hFF);
    chk("t4_wait_after_stray", {31'd0, ioctl_wait}, 32'h0);

    // 5: upload drops mid-fetch, then a fresh session
    mem_lat = 20;
    do_rd(25'h040, 1'b0, 8'h00, 0);
    repeat (2) @(negedge clk_sys);
    ioctl_upload = 1'b0;
    paused       = 1'b0;
    @(negedge clk_sys);
    chk("t5_pause_req", {31'd0, pause_req}, 32'h0);
    chk("t5_wait", {31'd0, ioctl_wait}, 32'h0);
    chk("t5_active", {31'd0, active}, 32'h0);
    chk("t5_err_kept", {31'd0, err}, 32'h1);
    repeat (25) @(negedge clk_sys);
    chk("t5_din_abandoned", {24'd0, ioctl_din}, 32'hFF);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    chk("t5_err_cleared", {31'd0, err}, 32'h0);
    chk("t5_pause_req_again", {31'd0, pause_req}, 32'h1);
    repeat (2) @(negedge clk_sys);
    paused = 1'b1;
    @(negedge clk_sys);
    mem_lat = 1;
    do_rd(25'h010, 1'b1, 8'hA5, 2);
    wait_done();
    chk("t5_err_clean", {31'd0, err}, 32'h0);

    // 6: second strobe during a fetch, reset mid-fetch, foreign index
    c0 = mem_rd_cnt;
    mem_lat = 6;
    do_rd(25'h020, 1'b1, 8'h95, 7);
    do_rd(25'h044, 1'b0, 8'h00, 0);
    wait_done();
    chk("t6_err_rd_in_wait", {31'd0, err}, 32'h1);
    chk("t6_single_fetch", mem_rd_cnt - c0, 1);
    mem_lat = 10;
    do_rd(25'h050, 1'b0, 8'h00, 0);
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_din", {24'd0, ioctl_din}, 32'h0);
    chk("t6_rst_wait", {31'd0, ioctl_wait}, 32'h0);
    chk("t6_rst_pause_req", {31'd0, pause_req}, 32'h0);
    chk("t6_rst_mem_addr", {20'd0, mem_addr}, 32'h0);
    chk("t6_rst_active", {31'd0, active}, 32'h0);
    chk("t6_rst_err", {31'd0, err}, 32'h0);
    ioctl_upload = 1'b0;
    paused       = 1'b0;
    repeat (15) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ioctl_index  = 8'd2;
    ioctl_upload = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("t6_idx2_pause_req", {31'd0, pause_req}, 32'h0);
    chk("t6_idx2_active", {31'd0, active}, 32'h0);
    chk("t6_idx2_wait", {31'd0, ioctl_wait}, 32'h0);
    c0 = mem_rd_cnt;
    do_rd(25'h010, 1'b0, 8'h00, 0);
    repeat (3) @(negedge clk_sys);
    chk("t6_idx2_no_mem_rd", mem_rd_cnt - c0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
